// File: rtl/rc_line_receiver.sv
// USB receive front end: SYNC qualification, NRZI decode, EOP detect.
// Ports: clk, rst (sync, active-high), dp/dm line samples in;
//   s_out/start_unstuffer/end_unstuffer bit stream to the unstuffer,
//   rcv_active packet window, line_error abort pulse out.
module rc_line_receiver #(
    parameter int MAX_BITS = 1100
) (
    input  logic clk,
    input  logic rst,
    input  logic dp,
    input  logic dm,
    output logic s_out,
    output logic start_unstuffer,
    output logic end_unstuffer,
    output logic rcv_active,
    output logic line_error
);

    localparam int CW = $clog2(MAX_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        RECV,
        EOP2,
        EOPJ,
        WAIT_J
    } state_t;

    state_t        state_q;
    logic [2:0]    idx_q;
    logic          prev_j_q;
    logic          pend_q;
    logic          pend_valid_q;
    logic          first_q;
    logic [CW-1:0] count_q;

    logic sym_j;
    logic sym_k;
    logic sym_se0;
    logic expect_k;
    logic sync_match;
    logic at_limit;

    assign sym_j   = dp & ~dm;
    assign sym_k   = ~dp & dm;
    assign sym_se0 = ~dp & ~dm;

    // SYNC is K J K J K J K K: J only at the odd indices below 7.
    assign expect_k   = ~(idx_q[0] && (idx_q != 3'd7));
    assign sync_match = expect_k ? sym_k : sym_j;

    assign at_limit = (count_q == CW'(MAX_BITS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            idx_q           <= 3'd0;
            prev_j_q        <= 1'b0;
            pend_q          <= 1'b0;
            pend_valid_q    <= 1'b0;
            first_q         <= 1'b1;
            count_q         <= '0;
            s_out           <= 1'b0;
            start_unstuffer <= 1'b0;
            end_unstuffer   <= 1'b0;
            rcv_active      <= 1'b0;
            line_error      <= 1'b0;
        end else begin
            start_unstuffer <= 1'b0;
            end_unstuffer   <= 1'b0;
            line_error      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sym_k) begin
                        state_q <= SYNC;
                        idx_q   <= 3'd1;
                    end else if (dp & dm) begin
                        line_error <= 1'b1;
                        state_q    <= WAIT_J;
                    end
                end
                SYNC: begin
                    if (!sync_match) begin
                        line_error <= 1'b1;
                        state_q    <= WAIT_J;
                    end else if (idx_q == 3'd7) begin
                        state_q      <= RECV;
                        prev_j_q     <= 1'b0;
                        pend_valid_q <= 1'b0;
                        first_q      <= 1'b1;
                        count_q      <= '0;
                        rcv_active   <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                RECV: begin
                    if (sym_j | sym_k) begin
                        if (pend_valid_q && at_limit) begin
                            line_error <= 1'b1;
                            rcv_active <= 1'b0;
                            state_q    <= WAIT_J;
                        end else begin
                            // No transition on the line decodes as a 1.
                            pend_q       <= (sym_j == prev_j_q);
                            pend_valid_q <= 1'b1;
                            prev_j_q     <= sym_j;
                            if (pend_valid_q) begin
                                s_out           <= pend_q;
                                start_unstuffer <= first_q;
                                first_q         <= 1'b0;
                                count_q         <= count_q + CW'(1);
                            end
                        end
                    end else if (sym_se0 && pend_valid_q && !at_limit) begin
                        // Flush the held bit as the last one of the packet.
                        s_out           <= pend_q;
                        end_unstuffer   <= 1'b1;
                        start_unstuffer <= first_q;
                        first_q         <= 1'b0;
                        pend_valid_q    <= 1'b0;
                        state_q         <= EOP2;
                    end else begin
                        line_error <= 1'b1;
                        rcv_active <= 1'b0;
                        state_q    <= WAIT_J;
                    end
                end
                EOP2: begin
                    if (sym_se0) begin
                        state_q <= EOPJ;
                    end else begin
                        line_error <= 1'b1;
                        rcv_active <= 1'b0;
                        state_q    <= WAIT_J;
                    end
                end
                EOPJ: begin
                    rcv_active <= 1'b0;
                    if (sym_j) begin
                        state_q <= IDLE;
                    end else begin
                        line_error <= 1'b1;
                        state_q    <= WAIT_J;
                    end
                end
                WAIT_J: begin
                    if (sym_j) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc_line_receiver.sv
// Self-checking bench for rc_line_receiver (MAX_BITS overridden to 16).
// Expected per-cycle outputs are queued as stimulus is driven.
module tb_rc_line_receiver;

    localparam int MAXB = 16;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;

    typedef struct packed {
        logic [1:0] sym;
        logic       c;
        logic       s;
        logic       st;
        logic       en;
        logic       act;
        logic       err;
    } vec_t;

    logic clk;
    logic rst;
    logic dp;
    logic dm;
    logic s_out;
    logic start_unstuffer;
    logic end_unstuffer;
    logic rcv_active;
    logic line_error;

    int    checks;
    int    errors;
    string tname;
    vec_t  sb[$];
    vec_t  tbl[20];

    rc_line_receiver #(
        .MAX_BITS(MAXB)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .dp             (dp),
        .dm             (dm),
        .s_out          (s_out),
        .start_unstuffer(start_unstuffer),
        .end_unstuffer  (end_unstuffer),
        .rcv_active     (rcv_active),
        .line_error     (line_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check();
        vec_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tname);
            return;
        end
        e = sb.pop_front();
        checks++;
        if ({start_unstuffer, end_unstuffer, rcv_active, line_error}
                !== {e.st, e.en, e.act, e.err} ||
            (e.c && (s_out !== e.s))) begin
            errors++;
            $display("FAIL %s chk %0d: got s=%b st=%b en=%b act=%b err=%b, exp s=%b(c=%b) st=%b en=%b act=%b err=%b",
                     tname, checks, s_out, start_unstuffer, end_unstuffer,
                     rcv_active, line_error, e.s, e.c, e.st, e.en, e.act, e.err);
        end
    endtask

    task automatic step(input logic [1:0] sym, input logic c,
                        input logic s, input logic st, input logic en,
                        input logic act, input logic err);
        vec_t e;
        e = '{sym, c, s, st, en, act, err};
        dp = sym[1];
        dm = sym[0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic idle(input logic [1:0] sym);
        step(sym, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sync_seq();
        idle(K); idle(J); idle(K); idle(J);
        idle(K); idle(J); idle(K);
        step(K, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Independent model: NRZI-encode bits (LSB first) from K, expect each
    // bit one sample later, and abort once MAXB bits have gone out.
    task automatic send_packet(input logic [31:0] bits, input int n);
        logic       pj;
        logic       lj;
        logic [1:0] sym;
        int         em;
        logic       ab;
        pj = 1'b0;
        em = 0;
        ab = 1'b0;
        sync_seq();
        for (int i = 0; i < n && !ab; i++) begin
            lj  = bits[i] ? pj : ~pj;
            pj  = lj;
            sym = lj ? J : K;
            if (i == 0) begin
                step(sym, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end else if (em == MAXB) begin
                step(sym, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                ab = 1'b1;
            end else begin
                step(sym, 1'b1, bits[i-1], (i == 1), 1'b0, 1'b1, 1'b0);
                em++;
            end
        end
        if (ab) begin
            idle(J);
        end else if (n == 0 || em == MAXB) begin
            step(SE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            idle(SE0);
            idle(J);
        end else begin
            step(SE0, 1'b1, bits[n-1], (n == 1), 1'b1, 1'b1, 1'b0);
            step(SE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            idle(J);
        end
        idle(J);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        dp     = 1'b1;
        dm     = 1'b0;

        // Clean packet: payload K K J K J K K K -> 1,1,0,0,0,0,1,1
        tbl[0]  = '{J,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{K,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{J,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{K,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{J,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{K,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{J,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{K,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{K,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{K,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{K,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{J,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{K,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{J,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{K,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{K,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{K,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{SE0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{SE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{J,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        tname = "reset";
        step(K, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(J, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        tname = "clean";
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].sym, tbl[i].c, tbl[i].s, tbl[i].st,
                 tbl[i].en, tbl[i].act, tbl[i].err);
        end

        tname = "bad_sync";
        idle(K); idle(J); idle(K);
        step(K, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(K); idle(SE1); idle(K); idle(J); idle(J);
        tname = "after_bad_sync";
        send_packet(32'h0000_00A5, 8);

        tname = "se1_mid";
        sync_seq();
        step(K, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(J, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(J, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(K, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(K, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(SE1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(SE0); idle(J); idle(J);
        tname = "after_se1";
        send_packet(32'h0000_3C96, 14);

        tname = "idle_se1";
        step(SE1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(K); idle(J);

        tname = "zero_len";
        send_packet(32'h0, 0);
        tname = "one_bit";
        send_packet(32'h1, 1);
        tname = "one_bit_zero";
        send_packet(32'h0, 1);

        tname = "len_16";
        send_packet(32'h0000_B5E3, 16);
        tname = "len_17";
        send_packet(32'h0001_7C4D, 17);
        tname = "len_20";
        send_packet(32'h000F_0F0F, 20);

        tname = "rst_mid";
        sync_seq();
        step(K, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(J, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(J, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step(SE0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(SE0); idle(J);
        tname = "after_rst";
        send_packet(32'h0000_00C3, 8);

        for (int r = 0; r < 6; r++) begin
            tname = $sformatf("rand_%0d", r);
            send_packet($urandom, int'($urandom_range(1, 16)));
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d queued, exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
